snake_dir_ctrl: RTL and testbench
=================================

// Module: snake_dir_ctrl
//
// PURPOSE
// Consumes the four clean, debounced push-button levels and turns them into
// snake turn commands for the game engine. Detects press edges, rejects
// illegal turns (180-degree reversal, repeat of the same heading), and buffers
// up to DEPTH accepted turns. The game engine pops one turn per game tick via
// a valid/ack handshake, so fast double-taps between ticks are not lost.
// Sits between the per-button debouncers and the game-tick/movement logic.
//
// PARAMETERS
// DEPTH      2     turn queue entries; legal range 1..4
// RESET_DIR  2'd1  heading after reset (encoding below; default = right)
//
// PORTS
// clk         in   1  system clock (50 MHz)
// rst         in   1  synchronous reset, active-high
// btn_up      in   1  debounced level, 1 = pressed
// btn_right   in   1  debounced level, 1 = pressed
// btn_down    in   1  debounced level, 1 = pressed
// btn_left    in   1  debounced level, 1 = pressed
// turn_ack    in   1  engine pops head of queue this cycle (game tick)
// turn_valid  out  1  queue non-empty
// turn_dir    out  2  head-of-queue heading; valid when turn_valid=1
// dir_out     out  2  committed heading used for movement
// drop_pulse  out  1  1-cycle pulse: a press edge was discarded
//
// BEHAVIOUR
// - Heading encoding: 00 up, 01 right, 10 down, 11 left. Reverse(d) = d ^ 2'b10.
// - Reset (rst=1 at posedge): queue empty, turn_valid=0, turn_dir=2'b00,
//   dir_out=RESET_DIR, drop_pulse=0. Edge registers load 1, so a button
//   already held through reset generates no press.
// - Edge detect: press = btn & ~btn_prev (registered). Edge sampled at
//   posedge N shows in the queue (turn_valid/turn_dir) after posedge N+1:
//   2-cycle latency from btn rising to turn_valid.
// - Simultaneous edges in one cycle: exactly one is considered, priority
//   up > right > down > left; the rest are discarded with drop_pulse=1.
// - Reference heading R = queue tail if queue non-empty, else dir_out.
// - Candidate d is accepted iff d != R and d != Reverse(R) and queue is
//   not full (after accounting for a same-cycle pop). Otherwise dropped,
//   drop_pulse=1 for one cycle. Queue state unchanged on a drop.
// - Pop: turn_ack=1 while turn_valid=1 -> dir_out <= turn_dir and head
//   advances, both visible next cycle. turn_ack while empty is ignored.
// - Push+pop in the same cycle: both happen; a full queue with a pop
//   accepts the push (occupancy unchanged). Empty queue: push only (no
//   bypass; turn_valid rises next cycle, pop the cycle after at earliest).
// - Reference check with one entry being popped uses that entry as R
//   (it becomes dir_out), so the result is consistent.
// - Storage: circular buffer, wr/rd pointers wrap at DEPTH, count 0..DEPTH.
// - rst asserted mid-operation: all queued turns discarded, dir_out back to
//   RESET_DIR on the next cycle; any press in that cycle is ignored.
// - Outputs are registered; no combinational path from inputs to outputs.
//
// TESTING
// 1 Reset with btn_up held high, release, no press -> turn_valid stays 0,
//   dir_out=01, drop_pulse never 1.
// 2 dir_out=01, press up (edge at cycle N) -> turn_valid=1, turn_dir=00
//   after posedge N+1; turn_ack 1 cycle -> dir_out=00, turn_valid=0.
// 3 dir_out=01, press left -> drop_pulse=1 one cycle, turn_valid stays 0;
//   press right -> dropped likewise (same heading).
// 4 DEPTH=2, dir_out=01: press up, left, down with no ack -> queue {00,11};
//   down dropped (full) with drop_pulse=1; two acks -> dir_out 00 then 11.
// 5 Edges on up and down in the same cycle -> only 00 queued, drop_pulse=1;
//   full queue + turn_ack + legal press same cycle -> count stays 2,
//   new entry at tail, no drop.
// 6 Queue holds 2 entries, assert rst 1 cycle -> turn_valid=0, dir_out=01
//   next cycle; subsequent turn_ack has no effect.

Source files
------------

// File: rtl/snake_dir_if.sv
// Bundle of button levels, turn handshake and status outputs between the
// debouncers/game engine and the snake direction controller.
interface snake_dir_if;
    logic       btn_up;
    logic       btn_right;
    logic       btn_down;
    logic       btn_left;
    logic       turn_ack;
    logic       turn_valid;
    logic [1:0] turn_dir;
    logic [1:0] dir_out;
    logic       drop_pulse;

    // Engine / stimulus side: drives buttons and pops turns
    modport master (
        output btn_up, btn_right, btn_down, btn_left, turn_ack,
        input  turn_valid, turn_dir, dir_out, drop_pulse
    );

    // Controller side
    modport slave (
        input  btn_up, btn_right, btn_down, btn_left, turn_ack,
        output turn_valid, turn_dir, dir_out, drop_pulse
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: turns debounced button presses into legal
// turn commands, queues up to DEPTH of them, and commits one per engine pop.
// Heading encoding: 00 up, 01 right, 10 down, 11 left; reverse = d ^ 2'b10.
module snake_dir_ctrl #(
    parameter int         DEPTH     = 2,
    parameter logic [1:0] RESET_DIR = 2'd1
) (
    input logic        clk,
    input logic        rst,
    snake_dir_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Button history and registered press edges (bit index = heading code)
    logic [3:0]    btn_prev_q, btn_prev_d;
    logic [3:0]    press_q, press_d;

    // Turn queue storage and control
    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Registered outputs
    logic [1:0]    dir_out_q, dir_out_d;
    logic          turn_valid_q, turn_valid_d;
    logic [1:0]    turn_dir_q, turn_dir_d;
    logic          drop_q, drop_d;

    // Internal decision signals
    logic          cand_vld;
    logic [1:0]    cand_dir;
    logic          multi_edge;
    logic          pop;
    logic          full_eff;
    logic          accept;
    logic [1:0]    ref_dir;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? LAST_PTR : p - PW'(1);
    endfunction

    // Edge detection, turn legality check and queue next-state
    always_comb begin
        btn_prev_d = {bus.btn_left, bus.btn_down, bus.btn_right, bus.btn_up};
        press_d    = btn_prev_d & ~btn_prev_q;

        // Fixed priority up > right > down > left among same-cycle edges
        cand_vld = |press_q;
        if (press_q[0])      cand_dir = 2'b00;
        else if (press_q[1]) cand_dir = 2'b01;
        else if (press_q[2]) cand_dir = 2'b10;
        else                 cand_dir = 2'b11;
        multi_edge = (press_q & (press_q - 4'd1)) != 4'd0;

        pop = bus.turn_ack && (count_q != '0);

        // The tail is what the snake will be heading after all queued turns;
        // when the only entry is being popped it is also the new dir_out.
        ref_dir  = (count_q != '0) ? mem_q[ptr_dec(wr_ptr_q)] : dir_out_q;
        full_eff = (count_q == FULL_CNT) && !pop;
        accept   = cand_vld && (cand_dir != ref_dir) &&
                   (cand_dir != (ref_dir ^ 2'b10)) && !full_eff;

        mem_d = mem_q;
        if (accept) mem_d[wr_ptr_q] = cand_dir;

        wr_ptr_d  = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q + CW'(accept) - CW'(pop);
        dir_out_d = pop ? mem_q[rd_ptr_q] : dir_out_q;

        turn_valid_d = (count_d != '0);
        turn_dir_d   = turn_valid_d ? mem_d[rd_ptr_d] : 2'b00;
        drop_d       = (cand_vld && !accept) || multi_edge;
    end

    // Control state with synchronous reset; edge history loads 1 so held buttons are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q   <= 4'b1111;
            press_q      <= 4'b0000;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dir_out_q    <= RESET_DIR;
            turn_valid_q <= 1'b0;
            turn_dir_q   <= 2'b00;
            drop_q       <= 1'b0;
        end else begin
            btn_prev_q   <= btn_prev_d;
            press_q      <= press_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dir_out_q    <= dir_out_d;
            turn_valid_q <= turn_valid_d;
            turn_dir_q   <= turn_dir_d;
            drop_q       <= drop_d;
        end
    end

    // Queue payload storage; contents are only meaningful under count_q
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.turn_valid = turn_valid_q;
    assign bus.turn_dir   = turn_dir_q;
    assign bus.dir_out    = dir_out_q;
    assign bus.drop_pulse = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed testbench for snake_dir_ctrl (DEPTH=2, RESET_DIR=right).
module tb_snake_dir_ctrl;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    snake_dir_if sif ();

    snake_dir_ctrl #(.DEPTH(2), .RESET_DIR(2'd1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] b);
        sif.btn_up    = b[0];
        sif.btn_right = b[1];
        sif.btn_down  = b[2];
        sif.btn_left  = b[3];
    endtask

    // Pulse buttons for one cycle; returns right after the queue has acted
    task automatic press(input logic [3:0] b);
        set_btns(b);
        step();
        set_btns(4'b0000);
        step();
    endtask

    task automatic ack();
        sif.turn_ack = 1'b1;
        step();
        sif.turn_ack = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        sif.turn_ack = 1'b0;
        set_btns(4'b0001);           // up held through reset
        step();
        step();
        chk("rst_valid", {1'b0, sif.turn_valid}, 2'd0);
        chk("rst_tdir",  sif.turn_dir, 2'b00);
        chk("rst_dir",   sif.dir_out, 2'b01);
        chk("rst_drop",  {1'b0, sif.drop_pulse}, 2'd0);

        // 1: held button released after reset produces no press
        rst = 1'b0;
        step();
        set_btns(4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_valid", {1'b0, sif.turn_valid}, 2'd0);
            chk("t1_drop",  {1'b0, sif.drop_pulse}, 2'd0);
        end
        chk("t1_dir", sif.dir_out, 2'b01);

        // 2: press up, two-cycle latency, then ack commits it
        set_btns(4'b0001);
        step();
        chk("t2_lat_valid", {1'b0, sif.turn_valid}, 2'd0);
        set_btns(4'b0000);
        step();
        chk("t2_valid", {1'b0, sif.turn_valid}, 2'd1);
        chk("t2_tdir",  sif.turn_dir, 2'b00);
        chk("t2_drop",  {1'b0, sif.drop_pulse}, 2'd0);
        ack();
        chk("t2_dir_after_ack", sif.dir_out, 2'b00);
        chk("t2_valid_after_ack", {1'b0, sif.turn_valid}, 2'd0);

        // Return heading to right
        press(4'b0010);
        chk("t3_setup_valid", {1'b0, sif.turn_valid}, 2'd1);
        ack();
        chk("t3_setup_dir", sif.dir_out, 2'b01);

        // 3: reversal and same-heading presses are dropped
        press(4'b1000);
        chk("t3_left_drop",  {1'b0, sif.drop_pulse}, 2'd1);
        chk("t3_left_valid", {1'b0, sif.turn_valid}, 2'd0);
        step();
        chk("t3_drop_one_cycle", {1'b0, sif.drop_pulse}, 2'd0);
        press(4'b0010);
        chk("t3_same_drop",  {1'b0, sif.drop_pulse}, 2'd1);
        chk("t3_same_valid", {1'b0, sif.turn_valid}, 2'd0);
        chk("t3_dir", sif.dir_out, 2'b01);

        // 4: fill the queue {up, left}; down rejected because full
        press(4'b0001);
        chk("t4_up_tdir", sif.turn_dir, 2'b00);
        chk("t4_up_drop", {1'b0, sif.drop_pulse}, 2'd0);
        press(4'b1000);
        chk("t4_left_drop", {1'b0, sif.drop_pulse}, 2'd0);
        press(4'b0100);
        chk("t4_full_drop", {1'b0, sif.drop_pulse}, 2'd1);
        chk("t4_full_tdir", sif.turn_dir, 2'b00);
        ack();
        chk("t4_ack1_dir",   sif.dir_out, 2'b00);
        chk("t4_ack1_valid", {1'b0, sif.turn_valid}, 2'd1);
        chk("t4_ack1_tdir",  sif.turn_dir, 2'b11);
        ack();
        chk("t4_ack2_dir",   sif.dir_out, 2'b11);
        chk("t4_ack2_valid", {1'b0, sif.turn_valid}, 2'd0);

        // 5a: simultaneous up+down edges, up wins, the rest is flagged
        press(4'b0101);
        chk("t5_multi_valid", {1'b0, sif.turn_valid}, 2'd1);
        chk("t5_multi_tdir",  sif.turn_dir, 2'b00);
        chk("t5_multi_drop",  {1'b0, sif.drop_pulse}, 2'd1);
        press(4'b0010);
        chk("t5_fill_drop", {1'b0, sif.drop_pulse}, 2'd0);

        // 5b: full queue, pop and legal push in the same cycle
        set_btns(4'b0100);
        step();
        set_btns(4'b0000);
        sif.turn_ack = 1'b1;
        step();
        sif.turn_ack = 1'b0;
        chk("t5_pp_drop",  {1'b0, sif.drop_pulse}, 2'd0);
        chk("t5_pp_dir",   sif.dir_out, 2'b00);
        chk("t5_pp_valid", {1'b0, sif.turn_valid}, 2'd1);
        chk("t5_pp_tdir",  sif.turn_dir, 2'b01);
        ack();
        chk("t5_pp2_dir",   sif.dir_out, 2'b01);
        chk("t5_pp2_valid", {1'b0, sif.turn_valid}, 2'd1);
        chk("t5_pp2_tdir",  sif.turn_dir, 2'b10);

        // 6: two entries queued, mid-run reset discards them
        press(4'b1000);
        chk("t6_fill_drop", {1'b0, sif.drop_pulse}, 2'd0);
        rst = 1'b1;
        set_btns(4'b0001);           // press during reset is ignored
        step();
        rst = 1'b0;
        chk("t6_rst_valid", {1'b0, sif.turn_valid}, 2'd0);
        chk("t6_rst_dir",   sif.dir_out, 2'b01);
        chk("t6_rst_tdir",  sif.turn_dir, 2'b00);
        ack();
        chk("t6_ack_dir",   sif.dir_out, 2'b01);
        chk("t6_ack_valid", {1'b0, sif.turn_valid}, 2'd0);
        set_btns(4'b0000);
        step();
        step();
        chk("t6_held_valid", {1'b0, sif.turn_valid}, 2'd0);
        chk("t6_held_drop",  {1'b0, sif.drop_pulse}, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
